// File: rtl/sync_fifo_if.sv
// rtl/sync_fifo_if.sv - handshake, data and status bundle for sync_fifo
interface sync_fifo_if #(
  parameter int SIZE_BITS = 7,
  parameter int WIDTH     = 8
);
  logic                 nwr;
  logic                 nrd;
  logic                 nclr;
  logic [WIDTH-1:0]     data_in;
  logic [WIDTH-1:0]     data_out;
  logic                 full;
  logic                 empty;
  logic                 almost_full;
  logic                 almost_empty;
  logic [SIZE_BITS:0]   level;
  logic                 overflow;
  logic                 underflow;

  // Producer/consumer side: drives requests and write data, observes status
  modport master (
    output nwr, nrd, nclr, data_in,
    input  data_out, full, empty, almost_full, almost_empty, level, overflow, underflow
  );

  // FIFO side
  modport slave (
    input  nwr, nrd, nclr, data_in,
    output data_out, full, empty, almost_full, almost_empty, level, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered or fall-through read
module sync_fifo #(
  parameter int SIZE_BITS = 7,
  parameter int WIDTH     = 8,
  parameter int FWFT      = 0,
  parameter int AF_LEVEL  = (1 << SIZE_BITS) - 1,
  parameter int AE_LEVEL  = 1
) (
  input  logic          clk,
  input  logic          nrst,
  sync_fifo_if.slave    bus
);
  localparam int                 DEPTH   = 1 << SIZE_BITS;
  localparam logic [SIZE_BITS:0] DEPTH_L = (SIZE_BITS+1)'(DEPTH);
  localparam logic [SIZE_BITS:0] AF_L    = (SIZE_BITS+1)'(AF_LEVEL);
  localparam logic [SIZE_BITS:0] AE_L    = (SIZE_BITS+1)'(AE_LEVEL);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [SIZE_BITS-1:0] w_ptr_q, w_ptr_d;
  logic [SIZE_BITS-1:0] r_ptr_q, r_ptr_d;
  logic [SIZE_BITS:0]   level_q, level_d;
  logic [WIDTH-1:0]     dout_q, dout_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;
  logic                 full, empty;
  logic                 wr_req, rd_req, wr_en, rd_en;

  // Acceptance uses only the pre-edge flags, so a same-edge read never frees room for a write
  always_comb begin
    full   = (level_q == DEPTH_L);
    empty  = (level_q == '0);
    wr_req = ~bus.nwr;
    rd_req = ~bus.nrd;
    wr_en  = wr_req & ~full;
    rd_en  = rd_req & ~empty;
  end

  // Next-state for pointers, level, registered read data and sticky error flags
  always_comb begin
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    level_d = level_q;
    dout_d  = dout_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;

    if (wr_en) w_ptr_d = w_ptr_q + 1'b1;
    if (rd_en) r_ptr_d = r_ptr_q + 1'b1;

    case ({wr_en, rd_en})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    if (FWFT == 0 && rd_en) dout_d = mem[r_ptr_q];

    // A fresh error wins over a clear in the same cycle
    if (wr_req && full)  ovf_d = 1'b1;
    else if (!bus.nclr)  ovf_d = 1'b0;
    if (rd_req && empty) unf_d = 1'b1;
    else if (!bus.nclr)  unf_d = 1'b0;
  end

  // Control state register with asynchronous clear
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      level_q <= '0;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      level_q <= level_d;
      dout_q  <= dout_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage array; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[w_ptr_q] <= bus.data_in;
  end

  // Fall-through mode shows the head entry directly; zero while empty keeps reset output at 0
  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.data_out = empty ? '0 : mem[r_ptr_q];
    end else begin : g_reg
      assign bus.data_out = dout_q;
    end
  endgenerate

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (level_q >= AF_L);
  assign bus.almost_empty = (level_q <= AE_L);
  assign bus.level        = level_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - randomized and directed check of sync_fifo in both read modes
module tb_sync_fifo;
  localparam int SB    = 2;
  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int AF    = 3;
  localparam int AE    = 1;

  logic         clk  = 1'b0;
  logic         nrst = 1'b0;
  logic         nwr  = 1'b1;
  logic         nrd  = 1'b1;
  logic         nclr = 1'b1;
  logic [W-1:0] din  = '0;

  always #5 clk = ~clk;

  sync_fifo_if #(.SIZE_BITS(SB), .WIDTH(W)) if0 ();
  sync_fifo_if #(.SIZE_BITS(SB), .WIDTH(W)) if1 ();

  assign if0.nwr = nwr;  assign if0.nrd = nrd;  assign if0.nclr = nclr;  assign if0.data_in = din;
  assign if1.nwr = nwr;  assign if1.nrd = nrd;  assign if1.nclr = nclr;  assign if1.data_in = din;

  sync_fifo #(.SIZE_BITS(SB), .WIDTH(W), .FWFT(0), .AF_LEVEL(AF), .AE_LEVEL(AE))
    dut0 (.clk(clk), .nrst(nrst), .bus(if0));
  sync_fifo #(.SIZE_BITS(SB), .WIDTH(W), .FWFT(1), .AF_LEVEL(AF), .AE_LEVEL(AE))
    dut1 (.clk(clk), .nrst(nrst), .bus(if1));

  // Reference model: a queue holds the contents in arrival order
  logic [W-1:0] mq[$];
  logic [W-1:0] m_dout0;
  bit           m_ovf, m_unf;
  bit           chk_en = 1'b0;
  int           cmp_sz;
  int           n_tests = 0;
  int           n_fail  = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_dout0 = '0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
  endtask

  // One clock of stimulus; w/r/c are active-high here for readability
  task automatic cycle(bit w, bit r, bit c, logic [W-1:0] d);
    int sz;
    bit wr_ok, rd_ok;
    nwr = ~w; nrd = ~r; nclr = ~c; din = d;
    @(posedge clk);
    if (nrst) begin
      sz    = mq.size();
      wr_ok = w && (sz < DEPTH);
      rd_ok = r && (sz > 0);
      if (rd_ok) m_dout0 = mq.pop_front();
      if (wr_ok) mq.push_back(d);
      m_ovf = (w && sz == DEPTH) ? 1'b1 : (c ? 1'b0 : m_ovf);
      m_unf = (r && sz == 0)     ? 1'b1 : (c ? 1'b0 : m_unf);
    end
    #1;
    nwr = 1'b1; nrd = 1'b1; nclr = 1'b1;
  endtask

  // Every falling edge: both DUTs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      cmp_sz = mq.size();
      check("level0",  if0.level,        cmp_sz);
      check("level1",  if1.level,        cmp_sz);
      check("full0",   if0.full,         cmp_sz == DEPTH);
      check("empty0",  if0.empty,        cmp_sz == 0);
      check("empty1",  if1.empty,        cmp_sz == 0);
      check("afull0",  if0.almost_full,  cmp_sz >= AF);
      check("aempty0", if0.almost_empty, cmp_sz <= AE);
      check("ovf0",    if0.overflow,     m_ovf);
      check("unf0",    if0.underflow,    m_unf);
      check("ovf1",    if1.overflow,     m_ovf);
      check("unf1",    if1.underflow,    m_unf);
      check("dout0",   if0.data_out,     m_dout0);
      if (cmp_sz > 0) check("dout1", if1.data_out, mq[0]);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;

    check("rst_empty",  if0.empty,        1);
    check("rst_level",  if0.level,        0);
    check("rst_dout",   if0.data_out,     0);
    check("rst_full",   if0.full,         0);
    check("rst_afull",  if0.almost_full,  0);
    check("rst_aempty", if0.almost_empty, 1);

    // Fill to full, then one rejected write
    for (int i = 1; i <= 4; i++) begin
      cycle(1, 0, 0, 8'(i * 8'h11));
      check("fill_level", if0.level, i);
      check("fill_afull", if0.almost_full, i >= 3);
      check("fill_full",  if0.full, i == 4);
    end
    cycle(1, 0, 0, 8'h55);
    check("ovf_set",   if0.overflow, 1);
    check("ovf_level", if0.level, 4);

    // Drain in order, then one rejected read
    for (int i = 1; i <= 4; i++) begin
      cycle(0, 1, 0, 8'h00);
      check("drain_dout", if0.data_out, i * 8'h11);
    end
    check("drain_empty", if0.empty, 1);
    cycle(0, 1, 0, 8'h00);
    check("unf_set",  if0.underflow, 1);
    check("unf_dout", if0.data_out, 8'h44);
    cycle(0, 0, 1, 8'h00);
    check("clr_ovf", if0.overflow, 0);
    check("clr_unf", if0.underflow, 0);

    // Fall-through: write appears on the next cycle
    cycle(1, 0, 0, 8'hA5);
    check("fwft_dout",  if1.data_out, 8'hA5);
    check("fwft_empty", if1.empty, 0);
    cycle(0, 1, 0, 8'h00);
    check("fwft_empty2", if1.empty, 1);

    // Simultaneous requests at full, empty and mid level
    for (int i = 1; i <= 4; i++) cycle(1, 0, 0, 8'(i));
    cycle(1, 1, 0, 8'h99);
    check("sim_full_level", if0.level, 3);
    check("sim_full_ovf",   if0.overflow, 1);
    check("sim_full_dout",  if0.data_out, 8'h01);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 8'h00);
    cycle(0, 0, 1, 8'h00);
    cycle(1, 1, 0, 8'h66);
    check("sim_empty_level", if0.level, 1);
    check("sim_empty_unf",   if0.underflow, 1);
    cycle(1, 0, 0, 8'h77);
    cycle(1, 1, 0, 8'h88);
    check("sim_mid_level", if0.level, 2);
    check("sim_mid_dout",  if0.data_out, 8'h66);
    cycle(0, 1, 0, 8'h00);
    cycle(0, 1, 0, 8'h00);

    // Ten write/read pairs run the pointers around more than twice
    for (int i = 0; i < 10; i++) begin
      cycle(1, 0, 0, 8'(8'h30 + i));
      cycle(0, 1, 0, 8'h00);
      check("wrap_dout", if0.data_out, 8'h30 + i);
    end
    cycle(0, 0, 1, 8'h00);
    check("wrap_clr_ovf", if0.overflow, 0);
    check("wrap_clr_unf", if0.underflow, 0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
            $urandom_range(0, 99) < 6, 8'($urandom));
    end

    // Asynchronous reset between edges at level 3
    while (mq.size() > 0) cycle(0, 1, 0, 8'h00);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 8'(8'hC0 + i));
    check("pre_rst_level", if0.level, 3);
    #2 nrst = 1'b0;
    model_reset();
    #1;
    check("arst_level", if0.level, 0);
    check("arst_empty", if0.empty, 1);
    check("arst_dout",  if0.data_out, 0);
    cycle(1, 1, 0, 8'hEE);
    check("rst_edge_level", if0.level, 0);
    #2 nrst = 1'b1;
    @(posedge clk); #1;
    cycle(1, 0, 0, 8'hBB);
    check("resume_level", if0.level, 1);
    check("resume_fwft",  if1.data_out, 8'hBB);
    cycle(0, 1, 0, 8'h00);
    check("resume_dout",  if0.data_out, 8'hBB);

    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter SIZE_BITS, default 7: depth = 2^SIZE_BITS entries, all usable.
REQ-002 SHALL have parameter WIDTH, default 8: data word width.
REQ-003 SHALL have parameter FWFT, default 0: 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-004 SHALL have parameter AF_LEVEL, default 2^SIZE_BITS-1: almost-full threshold.
REQ-005 SHALL have parameter AE_LEVEL, default 1: almost-empty threshold.
REQ-006 SHALL have port clk, input, 1: the single clock; all state changes on rising edge.
REQ-007 SHALL have port nrst, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port nwr, input, 1: active-low write request, sampled at rising clk.
REQ-009 SHALL have port nrd, input, 1: active-low read request, sampled at rising clk.
REQ-010 SHALL have port nclr, input, 1: active-low synchronous clear of error flags.
REQ-011 SHALL have port data_in, input, WIDTH: write data.
REQ-012 SHALL have port data_out, output, WIDTH: read data.
REQ-013 SHALL have port full, output, 1: level == depth.
REQ-014 SHALL have port empty, output, 1: level == 0.
REQ-015 SHALL have port almost_full, output, 1: level >= AF_LEVEL.
REQ-016 SHALL have port almost_empty, output, 1: level <= AE_LEVEL.
REQ-017 SHALL have port level, output, SIZE_BITS+1: current entry count, 0..depth.
REQ-018 SHALL have port overflow, output, 1: sticky rejected-write flag.
REQ-019 SHALL have port underflow, output, 1: sticky rejected-read flag.

Function
REQ-020 SHALL accept a write at a rising edge when nwr=0 and full=0: store data_in at w_ptr, w_ptr+1 modulo depth.
REQ-021 SHALL accept a read at a rising edge when nrd=0 and empty=0: r_ptr+1 modulo depth.
REQ-022 SHALL evaluate write and read acceptance from pre-edge full/empty only, so a simultaneous read does not admit a write when full, and a simultaneous write does not admit a read when empty.
REQ-023 SHALL update level at the same edge: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-024 SHALL derive full, empty, almost_full and almost_empty from the registered level, so they are valid in the cycle after the causing edge.
REQ-025 SHALL, with FWFT=0, load data_out with the entry at r_ptr on the accepting read edge, giving 1-cycle latency, and hold data_out otherwise.
REQ-026 SHALL, with FWFT=1, drive data_out with the entry at r_ptr whenever empty=0; a write into an empty FIFO SHALL appear on data_out in the next cycle; data_out is don't-care when empty=1.
REQ-027 SHALL set overflow at the edge where nwr=0 and full=1, and SHALL leave FIFO contents unchanged by that write.
REQ-028 SHALL set underflow at the edge where nrd=0 and empty=1, and SHALL leave r_ptr and data_out unchanged.
REQ-029 SHALL clear overflow and underflow at an edge with nclr=0; a simultaneous new error SHALL take priority and leave the flag set.
REQ-030 SHALL wrap pointers through depth-1 -> 0 without data corruption.

Reset
REQ-031 SHALL, when nrst=0 and asynchronously to clk, force w_ptr=0, r_ptr=0, level=0, data_out=0, overflow=0 and underflow=0, giving empty=1, almost_empty=1, full=0 and almost_full=0.
REQ-032 SHALL leave memory contents unreset.
REQ-033 SHALL, on reset asserted mid-operation, discard all entries, and SHALL accept no request at the edge coinciding with nrst=0.
REQ-034 SHALL resume normal operation at the first rising edge after nrst deasserts.

Verification (SIZE_BITS=2, WIDTH=8, AF_LEVEL=3, AE_LEVEL=1)
REQ-035 SHALL cover: write 0x11,0x22,0x33,0x44 -> level 1,2,3,4; almost_full at level 3; full after 4th write; fifth write 0x55 -> overflow=1, level stays 4.
REQ-036 SHALL cover: FWFT=0, read 4 from full -> data_out 0x11..0x44, each one cycle after its read edge; empty after last; extra read -> underflow=1, data_out stays 0x44.
REQ-037 SHALL cover: FWFT=1, single write 0xA5 into empty -> data_out=0xA5 and empty=0 next cycle; read -> empty=1.
REQ-038 SHALL cover: simultaneous nwr=0/nrd=0 at level 4 -> read accepted, write rejected, overflow=1, level 3; at level 0 -> write accepted, underflow=1, level 1; at level 2 -> level stays 2.
REQ-039 SHALL cover: 10 write/read pairs across pointer wrap -> data order preserved; then nclr=0 -> both error flags 0.
REQ-040 SHALL cover: nrst pulsed low between edges at level 3 -> level=0, empty=1, data_out=0 immediately, without waiting for a clock edge.
